md_scheduler: RTL

MD_SCHEDULER -- requirements
Module: md_scheduler

---
 rtl/md_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/md_scheduler.sv
// Multiply/divide unit scheduler: multi-cycle mult/div sequencing, HI/LO registers and ID-stage stall.
// Divide support is compiled only when MD_DIV_EN is defined.
module md_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_EX,
  input  logic [2:0]  md_op_EX,
  input  logic [31:0] rs_EX,
  input  logic [31:0] rt_EX,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic        sgn_reg, sgn_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        is_mul, is_div;
  logic [63:0] prod;

  assign is_mul = (md_op_EX == 3'd1) || (md_op_EX == 3'd2);

`ifdef MD_DIV_EN
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot, rem;

  assign is_div = (md_op_EX == 3'd3) || (md_op_EX == 3'd4);
  // Native signed division truncates toward zero and keeps the dividend's sign on the remainder.
  assign quot_s = $signed(a_reg) / $signed(b_reg);
  assign rem_s  = $signed(a_reg) % $signed(b_reg);
  assign quot   = sgn_reg ? $unsigned(quot_s) : (a_reg / b_reg);
  assign rem    = sgn_reg ? $unsigned(rem_s)  : (a_reg % b_reg);
`else
  assign is_div = 1'b0;
`endif

  always_comb begin
    if (sgn_reg)
      prod = $signed({{32{a_reg[31]}}, a_reg}) * $signed({{32{b_reg[31]}}, b_reg});
    else
      prod = {32'd0, a_reg} * {32'd0, b_reg};
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sgn_next   = sgn_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    case (state_reg)
      IDLE: begin
        if (start_EX) begin
          if (is_mul) begin
            a_next     = rs_EX;
            b_next     = rt_EX;
            sgn_next   = (md_op_EX == 3'd1);
            count_next = 4'd5;
            state_next = MULT;
          end else if (is_div) begin
            a_next     = rs_EX;
            b_next     = rt_EX;
            sgn_next   = (md_op_EX == 3'd3);
            count_next = 4'd10;
            state_next = DIV;
          end else if (md_op_EX == 3'd5) begin
            hi_next = rs_EX;
          end else if (md_op_EX == 3'd6) begin
            lo_next = rs_EX;
          end
        end
      end
      MULT: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          hi_next    = prod[63:32];
          lo_next    = prod[31:0];
          state_next = IDLE;
        end
      end
`ifdef MD_DIV_EN
      DIV: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          // A zero divisor still burns the full latency but leaves HI/LO alone.
          if (b_reg != 32'd0) begin
            hi_next = rem;
            lo_next = quot;
          end
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
      a_reg     <= 32'd0;
      b_reg     <= 32'd0;
      sgn_reg   <= 1'b0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sgn_reg   <= sgn_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy  = (state_reg != IDLE);
  assign stall = md_use_D & (busy | (start_EX & (is_mul | is_div)));
  assign hi    = hi_reg;
  assign lo    = lo_reg;

endmodule
